// File: rtl/csr_latch_sequencer_pkg.sv
// Shared types for the SR-latch sequencer.
// State encoding, command codes and S/R drive helpers.
package csr_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_CHECK
  } state_t;

  localparam logic [1:0] CMD_NOP = 2'b00;
  localparam logic [1:0] CMD_SET = 2'b01;
  localparam logic [1:0] CMD_RST = 2'b10;
  localparam logic [1:0] CMD_ILL = 2'b11;

  function automatic logic is_write(input logic [1:0] c);
    return (c == CMD_SET) || (c == CMD_RST);
  endfunction

  // Each line goes low only for its own command, so both low is impossible.
  function automatic logic drv_s_n(input logic [1:0] c);
    return !(c == CMD_SET);
  endfunction

  function automatic logic drv_r_n(input logic [1:0] c);
    return !(c == CMD_RST);
  endfunction

endpackage

// File: rtl/csr_latch_sequencer_if.sv
// Requester-side bus of the latch sequencer.
// Master drives requests, slave returns grant and status.
interface csr_latch_sequencer_if;
  logic [1:0] req;
  logic [1:0] cmd0;
  logic [1:0] cmd1;
  logic [1:0] gnt;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output req, cmd0, cmd1,
    input  gnt, busy, done, err
  );

  modport slave (
    input  req, cmd0, cmd1,
    output gnt, busy, done, err
  );
endinterface

// File: rtl/csr_latch_sequencer_arb.sv
// Two-input round-robin arbiter.
// Pointer holds the last winner; the other side wins a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic last;

  always_comb begin
    grant = req;
    if (req == 2'b11)
      grant = last ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last <= 1'b1;
    else if (en && (req != 2'b00))
      last <= grant[1];
  end

endmodule

// File: rtl/csr_latch_sequencer.sv
// Setup/pulse/hold sequencer for an active-low SR latch.
// Two requesters, round-robin, registered Moore outputs.
module csr_latch_sequencer
  import csr_seq_pkg::*;
#(
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned PULSE_CYC = 4,
  parameter int unsigned HOLD_CYC  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  csr_latch_sequencer_if.slave       bus,
  output logic                       latch_c,
  output logic                       latch_s_n,
  output logic                       latch_r_n,
  input  logic                       latch_q,
  input  logic                       latch_qbar
);

  localparam int unsigned M1 =
    (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int unsigned MX = (M1 > HOLD_CYC) ? M1 : HOLD_CYC;
  localparam int CW = $clog2(MX + 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    cmd_q, cmd_n;
  logic [1:0]    gnt_q, gnt_n;
  logic          busy_q, busy_n;
  logic          done_q, done_n;
  logic          err_q, err_n;
  logic          c_q, c_n;
  logic          s_q, s_n;
  logic          r_q, r_n;
  logic          arb_en;
  logic [1:0]    grant;
  logic [1:0]    sel;
  logic          ok;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (arb_en),
    .req   (bus.req),
    .grant (grant)
  );

  assign sel = grant[1] ? bus.cmd1 : bus.cmd0;
  assign ok  = (cmd_q == CMD_SET) ? (latch_q && !latch_qbar)
                                  : (!latch_q && latch_qbar);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cmd_n   = cmd_q;
    gnt_n   = 2'b00;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    c_n     = 1'b0;
    s_n     = 1'b1;
    r_n     = 1'b1;
    arb_en  = 1'b0;
    unique case (state)
      S_IDLE, S_CHECK: begin
        state_n = S_IDLE;
        // CHECK also accepts, giving zero-gap back-to-back service.
        if (bus.req != 2'b00) begin
          arb_en = 1'b1;
          cmd_n  = sel;
          gnt_n  = grant;
          busy_n = 1'b1;
          if (is_write(sel)) begin
            state_n = S_SETUP;
            cnt_n   = CW'(SETUP_CYC - 1);
            s_n     = drv_s_n(sel);
            r_n     = drv_r_n(sel);
          end else begin
            state_n = S_CHECK;
            done_n  = (sel == CMD_NOP);
            err_n   = (sel == CMD_ILL);
          end
        end
      end
      S_SETUP: begin
        busy_n = 1'b1;
        s_n    = drv_s_n(cmd_q);
        r_n    = drv_r_n(cmd_q);
        if (cnt == '0) begin
          state_n = S_PULSE;
          cnt_n   = CW'(PULSE_CYC - 1);
          c_n     = 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      S_PULSE: begin
        busy_n = 1'b1;
        s_n    = drv_s_n(cmd_q);
        r_n    = drv_r_n(cmd_q);
        c_n    = 1'b1;
        if (cnt == '0) begin
          state_n = S_HOLD;
          cnt_n   = CW'(HOLD_CYC - 1);
          c_n     = 1'b0;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      S_HOLD: begin
        busy_n = 1'b1;
        s_n    = drv_s_n(cmd_q);
        r_n    = drv_r_n(cmd_q);
        if (cnt == '0) begin
          // Verdict is taken here so done/err lands in the CHECK cycle.
          state_n = S_CHECK;
          s_n     = 1'b1;
          r_n     = 1'b1;
          done_n  = ok;
          err_n   = !ok;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      cmd_q  <= CMD_NOP;
      gnt_q  <= 2'b00;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      c_q    <= 1'b0;
      s_q    <= 1'b1;
      r_q    <= 1'b1;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      cmd_q  <= cmd_n;
      gnt_q  <= gnt_n;
      busy_q <= busy_n;
      done_q <= done_n;
      err_q  <= err_n;
      c_q    <= c_n;
      s_q    <= s_n;
      r_q    <= r_n;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;
  assign latch_c   = c_q;
  assign latch_s_n = s_q;
  assign latch_r_n = r_q;

endmodule

// File: tb/tb_csr_latch_sequencer.sv
// Directed bench for csr_latch_sequencer.
// Behavioural SR latch with optional stuck-at-0 Q.
module tb_csr_latch_sequencer;
  import csr_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic latch_c, latch_s_n, latch_r_n;
  logic latch_q, latch_qbar;
  logic q_model = 1'b0;
  logic stuck = 1'b0;
  int total = 0;
  int passed = 0;

  csr_latch_sequencer_if bus ();

  csr_latch_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .latch_c    (latch_c),
    .latch_s_n  (latch_s_n),
    .latch_r_n  (latch_r_n),
    .latch_q    (latch_q),
    .latch_qbar (latch_qbar)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (latch_c) begin
      if (!latch_s_n)      q_model <= 1'b1;
      else if (!latch_r_n) q_model <= 1'b0;
    end

  assign latch_q    = stuck ? 1'b0 : q_model;
  assign latch_qbar = ~latch_q;

  always @(negedge clk)
    if (!rst) begin
      total++;
      if (!latch_s_n && !latch_r_n)
        $display("FAIL sr_invariant t=%0t s_n=%b r_n=%b req 1x",
                 $time, latch_s_n, latch_r_n);
      else
        passed++;
    end

  // {gnt, busy, c, s_n, r_n, done, err} for write cycle k (1..9).
  function automatic logic [7:0] exp_wr(input int k, input logic [1:0] g,
                                         input logic [1:0] c, input bit ok);
    logic [1:0] eg;
    logic b, lc, s, r, d, e;
    eg = (k == 1) ? g : 2'b00;
    b  = (k >= 1) && (k <= 9);
    lc = (k >= 3) && (k <= 6);
    s  = !((c == CMD_SET) && (k >= 1) && (k <= 8));
    r  = !((c == CMD_RST) && (k >= 1) && (k <= 8));
    d  = (k == 9) && ok;
    e  = (k == 9) && !ok;
    return {eg, b, lc, s, r, d, e};
  endfunction

  function automatic logic [7:0] obs();
    return {bus.gnt, bus.busy, latch_c, latch_s_n, latch_r_n,
            bus.done, bus.err};
  endfunction

  task automatic test_reset;
    logic [7:0] o;
    bus.req = 2'b00; bus.cmd0 = CMD_NOP; bus.cmd1 = CMD_NOP;
    @(negedge clk);
    o = obs();
    total++;
    if (o !== 8'b00_0_0_1_1_0_0)
      $display("FAIL reset got %b exp %b", o, 8'b00_0_0_1_1_0_0);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_set;
    logic [7:0] o, e;
    @(negedge clk);
    bus.req = 2'b01; bus.cmd0 = CMD_SET;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) bus.req = 2'b00;
      o = obs(); e = exp_wr(k, 2'b01, CMD_SET, 1'b1);
      total++;
      if (o !== e) $display("FAIL set k=%0d got %b exp %b", k, o, e);
      else passed++;
    end
    total++;
    if (latch_q !== 1'b1) $display("FAIL set_q got %b exp 1", latch_q);
    else passed++;
  endtask

  task automatic test_reset_cmd;
    logic [7:0] o, e;
    @(negedge clk);
    bus.req = 2'b10; bus.cmd1 = CMD_RST;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) bus.req = 2'b00;
      o = obs(); e = exp_wr(k, 2'b10, CMD_RST, 1'b1);
      total++;
      if (o !== e) $display("FAIL rstcmd k=%0d got %b exp %b", k, o, e);
      else passed++;
    end
    total++;
    if (latch_q !== 1'b0) $display("FAIL rst_q got %b exp 0", latch_q);
    else passed++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] o, e;
    logic [1:0] g, c;
    int kk;
    @(negedge clk);
    bus.req = 2'b11; bus.cmd0 = CMD_SET; bus.cmd1 = CMD_RST;
    for (int k = 1; k <= 28; k++) begin
      @(negedge clk);
      if (k == 27) bus.req = 2'b00;
      if (k <= 27) begin
        kk = ((k - 1) % 9) + 1;
        g  = (((k - 1) / 9) == 1) ? 2'b10 : 2'b01;
        c  = (g == 2'b10) ? CMD_RST : CMD_SET;
        e  = exp_wr(kk, g, c, 1'b1);
      end else begin
        e = 8'b00_0_0_1_1_0_0;
      end
      o = obs();
      total++;
      if (o !== e) $display("FAIL b2b k=%0d got %b exp %b", k, o, e);
      else passed++;
    end
    total++;
    if (latch_q !== 1'b1) $display("FAIL b2b_q got %b exp 1", latch_q);
    else passed++;
  endtask

  task automatic test_nop_illegal;
    logic [7:0] o;
    @(negedge clk);
    bus.req = 2'b01; bus.cmd0 = CMD_ILL;
    @(negedge clk);
    bus.req = 2'b00;
    o = obs();
    total++;
    if (o !== 8'b01_1_0_1_1_0_1)
      $display("FAIL illegal got %b exp %b", o, 8'b01_1_0_1_1_0_1);
    else passed++;
    bus.req = 2'b01; bus.cmd0 = CMD_NOP;
    @(negedge clk);
    bus.req = 2'b00;
    o = obs();
    total++;
    if (o !== 8'b01_1_0_1_1_1_0)
      $display("FAIL nop got %b exp %b", o, 8'b01_1_0_1_1_1_0);
    else passed++;
    @(negedge clk);
    o = obs();
    total++;
    if (o !== 8'b00_0_0_1_1_0_0)
      $display("FAIL nop_idle got %b exp %b", o, 8'b00_0_0_1_1_0_0);
    else passed++;
  endtask

  task automatic test_stuck;
    logic [7:0] o, e;
    stuck = 1'b1;
    @(negedge clk);
    bus.req = 2'b01; bus.cmd0 = CMD_SET;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) bus.req = 2'b00;
      o = obs(); e = exp_wr(k, 2'b01, CMD_SET, 1'b0);
      total++;
      if (o !== e) $display("FAIL stuck k=%0d got %b exp %b", k, o, e);
      else passed++;
    end
    stuck = 1'b0;
  endtask

  task automatic test_abort;
    logic [7:0] o, e;
    @(negedge clk);
    bus.req = 2'b01; bus.cmd0 = CMD_SET;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) bus.req = 2'b00;
      o = obs(); e = exp_wr(k, 2'b01, CMD_SET, 1'b1);
      total++;
      if (o !== e) $display("FAIL abort_pre k=%0d got %b exp %b", k, o, e);
      else passed++;
    end
    rst = 1'b1;
    #1;
    o = obs();
    total++;
    if (o !== 8'b00_0_0_1_1_0_0)
      $display("FAIL abort_now got %b exp %b", o, 8'b00_0_0_1_1_0_0);
    else passed++;
    @(negedge clk);
    @(negedge clk);
    o = obs();
    total++;
    if (o !== 8'b00_0_0_1_1_0_0)
      $display("FAIL abort_hold got %b exp %b", o, 8'b00_0_0_1_1_0_0);
    else passed++;
    rst = 1'b0;
    bus.req = 2'b11; bus.cmd0 = CMD_SET; bus.cmd1 = CMD_RST;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) bus.req = 2'b00;
      o = obs(); e = exp_wr(k, 2'b01, CMD_SET, 1'b1);
      total++;
      if (o !== e) $display("FAIL abort_post k=%0d got %b exp %b", k, o, e);
      else passed++;
    end
    total++;
    if (latch_q !== 1'b1) $display("FAIL abort_q got %b exp 1", latch_q);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_set();
    test_reset_cmd();
    test_back_to_back();
    test_nop_illegal();
    test_stuck();
    test_abort();
    #2;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
